// File: rtl/aes_pkg.sv
// Shared definitions for the AES S-box time-sharing arbiter.
// Requester ids double as bit positions in the one-hot grant vector.
package aes_pkg;

    localparam int SBOX_WORD_W  = 32;
    localparam int SBOX_LAT_MAX = 3;

    localparam logic REQ_KG = 1'b0;
    localparam logic REQ_CP = 1'b1;

    typedef struct packed {
        logic v;
        logic id;
    } sbox_tag_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter with ack masking, key-gen priority override
// and the last-winner register; produces a one-hot grant each cycle.
module aes_rr_arb2
    import aes_pkg::*;
(
    input  logic       aclk,
    input  logic       areset,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       prio,
    output logic [1:0] grant
);

    logic [1:0] eligible;
    logic       last_grant;

    // A requester whose ack is currently high is still retiring its request.
    always_comb begin
        eligible = req & ~mask;
        grant    = '0;
        if (eligible[REQ_KG] && eligible[REQ_CP]) begin
            if (prio || (last_grant == REQ_CP)) begin
                grant[REQ_KG] = 1'b1;
            end else begin
                grant[REQ_CP] = 1'b1;
            end
        end else if (eligible[REQ_KG]) begin
            grant[REQ_KG] = 1'b1;
        end else if (eligible[REQ_CP]) begin
            grant[REQ_CP] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_grant <= REQ_CP;
        end else if (|grant) begin
            last_grant <= grant[REQ_CP] ? REQ_CP : REQ_KG;
        end
    end

endmodule

// File: rtl/aes_sbox_arbiter.sv
// Shares one external S-box word unit between key expansion and the cipher
// datapath; results come back in grant order via a tag shift line.
module aes_sbox_arbiter
    import aes_pkg::*;
#(
    parameter int SBOX_LAT = 0
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   kg_req,
    input  logic [SBOX_WORD_W-1:0] kg_data,
    output logic                   kg_ack,
    output logic                   kg_valid,
    output logic [SBOX_WORD_W-1:0] kg_result,
    input  logic                   cp_req,
    input  logic [SBOX_WORD_W-1:0] cp_data,
    output logic                   cp_ack,
    output logic                   cp_valid,
    output logic [SBOX_WORD_W-1:0] cp_result,
    input  logic                   kg_prio,
    output logic [SBOX_WORD_W-1:0] sbox_feed,
    input  logic [SBOX_WORD_W-1:0] new_sbox,
    output logic                   busy
);

    logic [1:0] grant;
    logic       win;
    logic       win_id;
    logic       busy_next;
    sbox_tag_t  tag_line [SBOX_LAT+1];
    sbox_tag_t  tag_next [SBOX_LAT+1];
    sbox_tag_t  tail;

    aes_rr_arb2 u_arb (
        .aclk   (aclk),
        .areset (areset),
        .req    ({cp_req, kg_req}),
        .mask   ({cp_ack, kg_ack}),
        .prio   (kg_prio),
        .grant  (grant)
    );

    assign win    = |grant;
    assign win_id = grant[REQ_CP];
    assign tail   = tag_line[SBOX_LAT];

    // The new tag enters at the head; busy covers the fresh grant plus every tag still in flight.
    always_comb begin
        tag_next[0] = '{v: win, id: win_id};
        for (int i = 1; i <= SBOX_LAT; i++) begin
            tag_next[i] = tag_line[i-1];
        end
        busy_next = 1'b0;
        for (int i = 0; i <= SBOX_LAT; i++) begin
            busy_next = busy_next | tag_next[i].v;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            kg_ack    <= 1'b0;
            cp_ack    <= 1'b0;
            kg_valid  <= 1'b0;
            cp_valid  <= 1'b0;
            kg_result <= '0;
            cp_result <= '0;
            sbox_feed <= '0;
            busy      <= 1'b0;
            for (int i = 0; i <= SBOX_LAT; i++) begin
                tag_line[i] <= '0;
            end
        end else begin
            kg_ack   <= grant[REQ_KG];
            cp_ack   <= grant[REQ_CP];
            busy     <= busy_next;
            kg_valid <= tail.v && (tail.id == REQ_KG);
            cp_valid <= tail.v && (tail.id == REQ_CP);
            for (int i = 0; i <= SBOX_LAT; i++) begin
                tag_line[i] <= tag_next[i];
            end
            if (win) begin
                sbox_feed <= win_id ? cp_data : kg_data;
            end
            if (tail.v && (tail.id == REQ_KG)) begin
                kg_result <= new_sbox;
            end
            if (tail.v && (tail.id == REQ_CP)) begin
                cp_result <= new_sbox;
            end
        end
    end

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Self-checking bench: four DUT copies (SBOX_LAT 0..3) share one stimulus stream
// and are checked every cycle against a grant-log model with a computed AES S-box.
module tb_aes_sbox_arbiter;

    localparam int MAXC = 6000;
    localparam int NLAT = 4;

    logic        aclk    = 1'b0;
    logic        areset  = 1'b1;
    logic        kg_req  = 1'b0;
    logic        cp_req  = 1'b0;
    logic        kg_prio = 1'b0;
    logic [31:0] kg_data = '0;
    logic [31:0] cp_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    // Grant log indexed by edge number: what was granted at that edge, and whether reset was seen.
    bit          g_valid [MAXC];
    bit          g_id    [MAXC];
    logic [31:0] g_data  [MAXC];
    bit          rst_at  [MAXC];
    bit          m_last;
    bit          m_ack_kg = 1'b0;
    bit          m_ack_cp = 1'b0;
    logic [31:0] exp_feed = '0;

    always #5 aclk = ~aclk;

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    // S-box = affine transform of the GF(2^8) inverse, inverse taken as x^254.
    function automatic logic [7:0] sbox_byte(logic [7:0] x);
        logic [7:0] inv, base, e;
        inv  = 8'h01;
        base = x;
        e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gf_mul(inv, base);
            base = gf_mul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
    endfunction

    function automatic bit no_reset_between(int a, int b);
        for (int i = a + 1; i <= b; i++) begin
            if (rst_at[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(string name, int lat, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s (lat %0d) at cycle %0d: got %h, required %h",
                     name, lat, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(bit kr, logic [31:0] kd, bit cr, logic [31:0] cd, bit pr);
        kg_req  = kr;
        kg_data = kd;
        cp_req  = cr;
        cp_data = cd;
        kg_prio = pr;
    endtask

    // Arbitration model: decides each edge's winner from the request rules and logs it.
    always @(posedge aclk) begin
        int n;
        bit ek, ec, wid;
        n = cyc + 1;
        if (n < MAXC) begin
            g_valid[n] = 1'b0;
            g_id[n]    = 1'b0;
            g_data[n]  = '0;
            rst_at[n]  = areset;
            if (areset) begin
                m_last   = 1'b1;
                exp_feed = '0;
            end else begin
                ek = kg_req && !m_ack_kg;
                ec = cp_req && !m_ack_cp;
                if (ek && ec) wid = (kg_prio || m_last) ? 1'b0 : 1'b1;
                else          wid = ec;
                if (ek || ec) begin
                    g_valid[n] = 1'b1;
                    g_id[n]    = wid;
                    g_data[n]  = wid ? cp_data : kg_data;
                    m_last     = wid;
                    exp_feed   = g_data[n];
                end
            end
            m_ack_kg = g_valid[n] && !g_id[n];
            m_ack_cp = g_valid[n] && g_id[n];
        end
        cyc = n;
    end

    for (genvar L = 0; L < NLAT; L++) begin : g_dut
        logic        ka, kv, ca, cv, busy;
        logic [31:0] kr, cr, feed, nsb;
        logic [31:0] pipe [4];
        logic [31:0] er_kg = '0;
        logic [31:0] er_cp = '0;

        aes_sbox_arbiter #(.SBOX_LAT(L)) dut (
            .aclk      (aclk),
            .areset    (areset),
            .kg_req    (kg_req),
            .kg_data   (kg_data),
            .kg_ack    (ka),
            .kg_valid  (kv),
            .kg_result (kr),
            .cp_req    (cp_req),
            .cp_data   (cp_data),
            .cp_ack    (ca),
            .cp_valid  (cv),
            .cp_result (cr),
            .kg_prio   (kg_prio),
            .sbox_feed (feed),
            .new_sbox  (nsb),
            .busy      (busy)
        );

        always @(posedge aclk) begin
            pipe[0] <= sub_word(feed);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        if (L == 0) begin : g_comb
            assign nsb = sub_word(feed);
        end else begin : g_reg
            assign nsb = pipe[L-1];
        end

        // A grant at edge gi shows valid in the interval after edge gi+1+L unless a reset intervened.
        always @(negedge aclk) begin
            int t, gi;
            bit ekv, ecv, eb;
            if (cyc > 0 && cyc < MAXC && !done) begin
                t   = cyc;
                gi  = t - 1 - L;
                ekv = 1'b0;
                ecv = 1'b0;
                if (rst_at[t]) begin
                    er_kg = '0;
                    er_cp = '0;
                end else if (gi >= 1 && g_valid[gi] && no_reset_between(gi, t)) begin
                    if (g_id[gi]) begin
                        ecv   = 1'b1;
                        er_cp = sub_word(g_data[gi]);
                    end else begin
                        ekv   = 1'b1;
                        er_kg = sub_word(g_data[gi]);
                    end
                end
                eb = 1'b0;
                for (int i = t - L; i <= t; i++) begin
                    if (i >= 1 && g_valid[i] && no_reset_between(i, t)) eb = 1'b1;
                end
                checkOutput("kg_ack",    L, 32'(ka), 32'(g_valid[t] && !g_id[t]));
                checkOutput("cp_ack",    L, 32'(ca), 32'(g_valid[t] && g_id[t]));
                checkOutput("kg_valid",  L, 32'(kv), 32'(ekv));
                checkOutput("cp_valid",  L, 32'(cv), 32'(ecv));
                checkOutput("kg_result", L, kr, er_kg);
                checkOutput("cp_result", L, cr, er_cp);
                checkOutput("sbox_feed", L, feed, exp_feed);
                checkOutput("busy",      L, 32'(busy), 32'(eb));
            end
        end
    end

    task automatic idle(int n);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (n) @(negedge aclk);
    endtask

    initial begin
        bit          kr, cr, pr;
        logic [31:0] kd, cd;

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        checkOutput("lit_reset_busy", 0, 32'(g_dut[0].busy), 32'd0);
        checkOutput("lit_reset_feed", 3, g_dut[3].feed, 32'd0);
        idle(3);

        $display("[TB] contention, round-robin");
        applyStimulus(1'b1, 32'h09CF4F3C, 1'b1, 32'h00000000, 1'b0);
        @(negedge aclk);
        checkOutput("lit_first_contest_kg", 0, 32'(g_dut[0].ka), 32'd1);
        @(negedge aclk);
        checkOutput("lit_rr_cp_ack", 0, 32'(g_dut[0].ca), 32'd1);
        checkOutput("lit_kg_result", 0, g_dut[0].kr, 32'h018A84EB);
        @(negedge aclk);
        checkOutput("lit_rr_kg_ack", 0, 32'(g_dut[0].ka), 32'd1);
        checkOutput("lit_cp_result", 0, g_dut[0].cr, 32'h63636363);
        repeat (6) @(negedge aclk);
        idle(6);

        $display("[TB] single key-gen request");
        applyStimulus(1'b1, 32'h09CF4F3C, 1'b0, '0, 1'b0);
        @(negedge aclk);
        checkOutput("lit_single_ack",  0, 32'(g_dut[0].ka), 32'd1);
        checkOutput("lit_single_feed", 0, g_dut[0].feed, 32'h09CF4F3C);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge aclk);
        checkOutput("lit_single_valid", 0, 32'(g_dut[0].kv), 32'd1);
        checkOutput("lit_single_res",   0, g_dut[0].kr, 32'h018A84EB);
        checkOutput("lit_single_cpv",   0, 32'(g_dut[0].cv), 32'd0);
        idle(4);

        $display("[TB] priority override");
        applyStimulus(1'b1, 32'hA5A5_0F0F, 1'b1, 32'h1234_5678, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge aclk);
            checkOutput("lit_prio_kg_ack", 1, 32'(g_dut[1].ka), 32'(i % 2));
            checkOutput("lit_prio_cp_ack", 1, 32'(g_dut[1].ca), 32'((i + 1) % 2));
        end
        kg_prio = 1'b0;
        repeat (6) @(negedge aclk);
        idle(8);

        $display("[TB] reset mid-flight");
        applyStimulus(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge aclk);
        checkOutput("lit_mid_cp_ack", 2, 32'(g_dut[2].ca), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        checkOutput("lit_mid_busy", 2, 32'(g_dut[2].busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checkOutput("lit_mid_no_valid", 2, 32'(g_dut[2].cv), 32'd0);
        end
        applyStimulus(1'b1, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b0);
        @(negedge aclk);
        checkOutput("lit_mid_kg_wins", 2, 32'(g_dut[2].ka), 32'd1);
        idle(6);

        $display("[TB] randomized traffic");
        kr = 1'b0; cr = 1'b0; pr = 1'b0; kd = '0; cd = '0;
        for (int i = 0; i < 2500; i++) begin
            if (areset) areset = ($urandom_range(0, 2) == 0);
            else        areset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) pr = ~pr;
            if (!kr) begin
                if ($urandom_range(0, 9) < 5) begin kr = 1'b1; kd = $urandom; end
            end else if (m_ack_kg) begin
                if ($urandom_range(0, 1) == 0) kr = 1'b0;
                else kd = $urandom;
            end
            if (!cr) begin
                if ($urandom_range(0, 9) < 5) begin cr = 1'b1; cd = $urandom; end
            end else if (m_ack_cp) begin
                if ($urandom_range(0, 1) == 0) cr = 1'b0;
                else cd = $urandom;
            end
            applyStimulus(kr, kd, cr, cd, pr);
            @(negedge aclk);
        end
        areset = 1'b0;
        idle(10);

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
